// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared types and constants for the spi_reg_slave block.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } spi_state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: brings sclk/mosi/csn into the clk domain and produces
// registered edge pulses; all outputs are aligned to the edge pulses.
module spi_pin_sync
  import spi_reg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic mosi,
  input  logic csn,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic csn_rise,
  output logic csn_fall,
  output logic csn_level,
  output logic mosi_level
);

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] csn_sync_r;
  logic                   sclk_d_r;
  logic                   mosi_d_r;
  logic                   csn_d_r;
  logic                   sclk_rise_r;
  logic                   sclk_fall_r;
  logic                   csn_rise_r;
  logic                   csn_fall_r;

  // Synchroniser chains plus one detect stage. csn resets low on purpose:
  // a reset taken while csn is held low must not look like a fresh csn fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_r <= '0;
      mosi_sync_r <= '0;
      csn_sync_r  <= '0;
      sclk_d_r    <= 1'b0;
      mosi_d_r    <= 1'b0;
      csn_d_r     <= 1'b0;
      sclk_rise_r <= 1'b0;
      sclk_fall_r <= 1'b0;
      csn_rise_r  <= 1'b0;
      csn_fall_r  <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      csn_sync_r  <= {csn_sync_r[SYNC_STAGES-2:0], csn};
      sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
      mosi_d_r    <= mosi_sync_r[SYNC_STAGES-1];
      csn_d_r     <= csn_sync_r[SYNC_STAGES-1];
      sclk_rise_r <= sclk_sync_r[SYNC_STAGES-1] & ~sclk_d_r;
      sclk_fall_r <= ~sclk_sync_r[SYNC_STAGES-1] & sclk_d_r;
      csn_rise_r  <= csn_sync_r[SYNC_STAGES-1] & ~csn_d_r;
      csn_fall_r  <= ~csn_sync_r[SYNC_STAGES-1] & csn_d_r;
    end
  end

  assign sclk_rise  = sclk_rise_r;
  assign sclk_fall  = sclk_fall_r;
  assign csn_rise   = csn_rise_r;
  assign csn_fall   = csn_fall_r;
  assign csn_level  = csn_d_r;
  assign mosi_level = mosi_d_r;

endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI mode-0 slave with a parallel-visible register file.
// Define SPI_REG_BURST_EN for auto-incrementing multi-word frames.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sclk,
  input  logic                     mosi,
  input  logic                     csn,
  output logic                     miso,
  output logic                     miso_oe,
  output logic [DEPTH*DATA_W-1:0]  reg_q,
  output logic                     wr_strobe,
  output logic [ADDR_W-1:0]        wr_addr
);

  localparam int MAX_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int CNT_W = $clog2(MAX_W);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(DEPTH));
  endfunction

  // Unimplemented addresses read as zero because no index matches them.
  function automatic logic [DATA_W-1:0] read_word(input logic [DEPTH*DATA_W-1:0] regs,
                                                  input logic [ADDR_W-1:0]       a);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a == ADDR_W'(i)) w = regs[i*DATA_W +: DATA_W];
    end
    return w;
  endfunction

  logic sclk_rise_s;
  logic sclk_fall_s;
  logic csn_rise_s;
  logic csn_fall_s;
  logic csn_level_s;
  logic mosi_level_s;

  spi_state_e state_r;
  spi_state_e state_nxt_s;

  logic [CNT_W-1:0]        cnt_r;
  logic                    rw_r;
  logic [ADDR_W-2:0]       addr_sh_r;
  logic [ADDR_W-1:0]       addr_r;
  logic [DATA_W-2:0]       data_sh_r;
  logic [DATA_W-1:0]       tx_r;
  logic                    miso_r;
  logic                    miso_oe_r;
  logic [DEPTH*DATA_W-1:0] reg_q_r;
  logic                    wr_strobe_r;
  logic [ADDR_W-1:0]       wr_addr_r;

  logic                    abort_s;
  logic [ADDR_W-1:0]       addr_in_s;
  logic [DATA_W-1:0]       data_in_s;
  logic                    addr_last_s;
  logic                    data_last_s;
  logic                    commit_s;
  logic                    load_s;
  logic                    miso_oe_nxt_s;
  logic [ADDR_W-1:0]       rd_addr_s;
  logic [DATA_W-1:0]       rd_word_s;
`ifdef SPI_REG_BURST_EN
  logic [ADDR_W-1:0]       addr_inc_s;
`endif

  spi_pin_sync u_pin_sync (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .mosi       (mosi),
    .csn        (csn),
    .sclk_rise  (sclk_rise_s),
    .sclk_fall  (sclk_fall_s),
    .csn_rise   (csn_rise_s),
    .csn_fall   (csn_fall_s),
    .csn_level  (csn_level_s),
    .mosi_level (mosi_level_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; csn high overrides everything, including a last-bit rise.
  always_comb begin
    state_nxt_s = state_r;
    if (abort_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (csn_fall_s) state_nxt_s = CMD;
          else            state_nxt_s = IDLE;
        end
        CMD: begin
          if (sclk_rise_s) state_nxt_s = ADDR;
          else             state_nxt_s = CMD;
        end
        ADDR: begin
          if (addr_last_s) state_nxt_s = DATA;
          else             state_nxt_s = ADDR;
        end
        DATA: begin
`ifdef SPI_REG_BURST_EN
          state_nxt_s = DATA;
`else
          if (data_last_s) state_nxt_s = DONE;
          else             state_nxt_s = DATA;
`endif
        end
        DONE:    state_nxt_s = DONE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM outputs and datapath controls.
  always_comb begin
    abort_s       = csn_level_s | csn_rise_s;
    addr_in_s     = {addr_sh_r, mosi_level_s};
    data_in_s     = {data_sh_r, mosi_level_s};
    addr_last_s   = (state_r == ADDR) && sclk_rise_s && (cnt_r == CNT_W'(ADDR_W - 1));
    data_last_s   = (state_r == DATA) && sclk_rise_s && (cnt_r == CNT_W'(DATA_W - 1));
    commit_s      = data_last_s && !abort_s && (rw_r == OP_WRITE) && in_range(addr_r);
    miso_oe_nxt_s = (state_nxt_s == DATA) && (rw_r == OP_READ);
`ifdef SPI_REG_BURST_EN
    addr_inc_s    = (addr_r == ADDR_W'(DEPTH - 1)) ? '0 : addr_r + ADDR_W'(1);
    load_s        = addr_last_s || data_last_s;
    rd_addr_s     = (state_r == DATA) ? addr_inc_s : addr_in_s;
`else
    load_s        = addr_last_s;
    rd_addr_s     = addr_in_s;
`endif
    rd_word_s     = read_word(reg_q_r, rd_addr_s);
  end

  // Shift registers, bit counter, register file and registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= '0;
      rw_r        <= OP_READ;
      addr_sh_r   <= '0;
      addr_r      <= '0;
      data_sh_r   <= '0;
      tx_r        <= '0;
      miso_r      <= 1'b0;
      miso_oe_r   <= 1'b0;
      reg_q_r     <= '0;
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= '0;
    end else begin
      wr_strobe_r <= 1'b0;
      miso_oe_r   <= miso_oe_nxt_s;

      if ((state_nxt_s != state_r) || data_last_s) begin
        cnt_r <= '0;
      end else if (sclk_rise_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end

      if (sclk_rise_s && !abort_s) begin
        if (state_r == CMD)  rw_r      <= mosi_level_s;
        if (state_r == ADDR) addr_sh_r <= addr_in_s[ADDR_W-2:0];
        if (state_r == DATA) data_sh_r <= data_in_s[DATA_W-2:0];
        if (addr_last_s)     addr_r    <= addr_in_s;
`ifdef SPI_REG_BURST_EN
        if (data_last_s)     addr_r    <= addr_inc_s;
`endif
      end

      // The MSB of a freshly loaded word goes out on the following fall.
      if (load_s) begin
        tx_r <= rd_word_s;
      end else if (sclk_fall_s && (state_r == DATA)) begin
        tx_r <= {tx_r[DATA_W-2:0], 1'b0};
      end

      if (!miso_oe_nxt_s) begin
        miso_r <= 1'b0;
      end else if (sclk_fall_s && (state_r == DATA)) begin
        miso_r <= tx_r[DATA_W-1];
      end

      if (commit_s) begin
        wr_strobe_r <= 1'b1;
        wr_addr_r   <= addr_r;
        for (int i = 0; i < DEPTH; i++) begin
          if (addr_r == ADDR_W'(i)) reg_q_r[i*DATA_W +: DATA_W] <= data_in_s;
        end
      end
    end
  end

  assign miso      = miso_r;
  assign miso_oe   = miso_oe_r;
  assign reg_q     = reg_q_r;
  assign wr_strobe = wr_strobe_r;
  assign wr_addr   = wr_addr_r;

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: randomized SPI frames checked against an array model of
// the register file; honours SPI_REG_BURST_EN like the design.
module tb_spi_reg_slave;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 32;
  localparam int HALF  = 6;
`ifdef SPI_REG_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic                  clk  = 1'b0;
  logic                  rst  = 1'b1;
  logic                  sclk = 1'b0;
  logic                  mosi = 1'b0;
  logic                  csn  = 1'b1;
  logic                  miso;
  logic                  miso_oe;
  logic [DEPTH*DW-1:0]   reg_q;
  logic                  wr_strobe;
  logic [AW-1:0]         wr_addr;

  always #5 clk = ~clk;

  spi_reg_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .mosi      (mosi),
    .csn       (csn),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .reg_q     (reg_q),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mdl [DEPTH];

  int            strobe_edges  = 0;
  int            strobe_cycles = 0;
  logic          strobe_prev   = 1'b0;
  logic [AW-1:0] strobe_log [$];
  int            miso_leak     = 0;

  // Observe strobe pulses and miso while disabled, away from the active edge.
  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cycles++;
      if (!strobe_prev) begin
        strobe_edges++;
        strobe_log.push_back(wr_addr);
      end
    end
    strobe_prev = wr_strobe;
    if (!miso_oe && miso) miso_leak++;
  end

  task automatic chk(input string tag, input logic [DEPTH*DW-1:0] got,
                     input logic [DEPTH*DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DEPTH*DW-1:0] model_flat();
    logic [DEPTH*DW-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i*DW +: DW] = mdl[i];
    return v;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master side of one frame. cut >= 0 raises csn after that many data bits;
  // rst_at >= 0 pulses rst before that data bit and checks the reset state.
  task automatic spi_xfer(input logic rw, input logic [AW-1:0] addr, input int nwords,
                          input logic [3*DW-1:0] wdata, input int cut, input bit csn_on_last,
                          input int rst_at, output logic [3*DW-1:0] rdata, output int oe_bad);
    int   nbits;
    int   stop;
    int   d;
    logic b;
    logic exp_oe;
    nbits  = 1 + AW + nwords * DW;
    stop   = (cut >= 0) ? 1 + AW + cut : nbits;
    rdata  = '0;
    oe_bad = 0;
    csn    = 1'b0;
    wait_clk(2);
    for (int k = 0; k < stop; k++) begin
      if (rst_at >= 0 && k == 1 + AW + rst_at) begin
        rst = 1'b1;
        wait_clk(1);
        chk("rst_regq", reg_q, '0);
        chk("rst_miso", miso, 1'b0);
        chk("rst_oe", miso_oe, 1'b0);
        chk("rst_strobe", wr_strobe, 1'b0);
        chk("rst_waddr", wr_addr, '0);
        rst = 1'b0;
      end
      if (k == 0)       b = rw;
      else if (k <= AW) b = addr[AW-k];
      else              b = wdata[nwords*DW-1-(k-1-AW)];
      mosi = b;
      wait_clk(HALF);
      if (k > AW) begin
        d      = k - 1 - AW;
        rdata  = {rdata[3*DW-2:0], miso};
        exp_oe = (rw == 1'b0) && (rst_at < 0) && (BURST || d < DW);
        if (miso_oe !== exp_oe) oe_bad++;
      end
      if (csn_on_last && k == nbits - 1) csn = 1'b1;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    wait_clk(HALF);
    csn = 1'b1;
    wait_clk(10);
  endtask

  logic [3*DW-1:0] rd;
  int              oeb;
  int              e0;
  int              c0;
  int              lb;
  logic            rw_t;
  logic [AW-1:0]   a_t;
  logic [DW-1:0]   d_t;
  logic [DW-1:0]   w0, w1, w2;

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(3);
    chk("reset_regq", reg_q, '0);
    chk("reset_miso", miso, 1'b0);
    chk("reset_oe", miso_oe, 1'b0);
    chk("reset_strobe", wr_strobe, 1'b0);
    chk("reset_waddr", wr_addr, '0);

    // Directed write then read-back of address 3.
    e0 = strobe_edges; c0 = strobe_cycles;
    spi_xfer(1'b1, 8'd3, 1, 48'hA5C3, -1, 1'b0, -1, rd, oeb);
    mdl[3] = 16'hA5C3;
    chk("wr3_edges", strobe_edges - e0, 1);
    chk("wr3_cycles", strobe_cycles - c0, 1);
    chk("wr3_addr", wr_addr, 8'd3);
    chk("wr3_regq", reg_q, model_flat());
    chk("wr3_oe", oeb, 0);
    spi_xfer(1'b0, 8'd3, 1, 48'h0, -1, 1'b0, -1, rd, oeb);
    chk("rd3_data", rd[DW-1:0], 16'hA5C3);
    chk("rd3_oe", oeb, 0);
    chk("rd3_oe_after", miso_oe, 1'b0);

    // Out-of-range address: write dropped, read returns zero.
    e0 = strobe_edges;
    spi_xfer(1'b1, 8'd40, 1, 48'h1234, -1, 1'b0, -1, rd, oeb);
    chk("wr40_edges", strobe_edges - e0, 0);
    chk("wr40_regq", reg_q, model_flat());
    spi_xfer(1'b0, 8'd40, 1, 48'h0, -1, 1'b0, -1, rd, oeb);
    chk("rd40_data", rd[DW-1:0], 16'h0000);

    // Abort after 10 data bits, then a normal frame to the same address.
    e0 = strobe_edges;
    spi_xfer(1'b1, 8'd7, 1, 48'hBEEF, 10, 1'b0, -1, rd, oeb);
    chk("abort_edges", strobe_edges - e0, 0);
    chk("abort_regq", reg_q, model_flat());
    spi_xfer(1'b1, 8'd7, 1, 48'hBEEF, -1, 1'b0, -1, rd, oeb);
    mdl[7] = 16'hBEEF;
    chk("after_abort_edges", strobe_edges - e0, 1);
    chk("after_abort_regq", reg_q, model_flat());

    // csn rises together with the last data bit: write must be lost.
    e0 = strobe_edges;
    spi_xfer(1'b1, 8'd9, 1, 48'h0F0F, -1, 1'b1, -1, rd, oeb);
    chk("race_edges", strobe_edges - e0, 0);
    chk("race_regq", reg_q, model_flat());

    // Randomized single-word frames.
    for (int n = 0; n < 40; n++) begin
      rw_t = 1'($urandom_range(0, 1));
      a_t  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
      d_t  = 16'($urandom);
      e0   = strobe_edges;
      spi_xfer(rw_t, a_t, 1, {32'h0, d_t}, -1, 1'b0, -1, rd, oeb);
      if (rw_t && a_t < DEPTH) begin
        mdl[a_t] = d_t;
        chk("rnd_edges", strobe_edges - e0, 1);
        chk("rnd_waddr", wr_addr, a_t);
      end else begin
        chk("rnd_edges", strobe_edges - e0, 0);
      end
      if (!rw_t) chk("rnd_rdata", rd[DW-1:0], (a_t < DEPTH) ? mdl[a_t] : 16'h0);
      chk("rnd_oe", oeb, 0);
      chk("rnd_regq", reg_q, model_flat());
    end
    chk("strobe_width", strobe_cycles, strobe_edges);

    // Three-word frame starting at the last register.
    w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom);
    e0 = strobe_edges;
    lb = strobe_log.size();
    spi_xfer(1'b1, 8'd31, 3, {w0, w1, w2}, -1, 1'b0, -1, rd, oeb);
    mdl[31] = w0;
    if (BURST) begin
      mdl[0] = w1;
      mdl[1] = w2;
    end
    chk("burst_edges", strobe_edges - e0, BURST ? 3 : 1);
    chk("burst_log0", strobe_log[lb], 8'd31);
    if (BURST) begin
      chk("burst_log1", strobe_log[lb+1], 8'd0);
      chk("burst_log2", strobe_log[lb+2], 8'd1);
    end
    chk("burst_regq", reg_q, model_flat());
    spi_xfer(1'b0, 8'd31, 2, 48'h0, -1, 1'b0, -1, rd, oeb);
    chk("burst_rdata", rd[2*DW-1:0], BURST ? {mdl[31], mdl[0]} : {mdl[31], 16'h0});
    chk("burst_rd_oe", oeb, 0);

    // Reset in the middle of a write frame; leftover edges must be ignored.
    e0 = strobe_edges;
    spi_xfer(1'b1, 8'd12, 1, 48'h5A5A, -1, 1'b0, 5, rd, oeb);
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    chk("midrst_edges", strobe_edges - e0, 0);
    chk("midrst_regq", reg_q, model_flat());
    spi_xfer(1'b1, 8'd12, 1, 48'h5A5A, -1, 1'b0, -1, rd, oeb);
    mdl[12] = 16'h5A5A;
    chk("postrst_edges", strobe_edges - e0, 1);
    chk("postrst_regq", reg_q, model_flat());

    chk("miso_leak", miso_leak, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
